// File: rtl/crddrop_multi.sv
// crddrop_multi: joins one coordinate stream with NUM_CH value streams and drops zero elements.
// Optional drop/pass counters are enabled with `define CRDDROP_MULTI_STATS_EN.
module crddrop_multi #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         tile_en,
  input  logic                         drop_mode,
  input  logic [DATA_WIDTH:0]          coord_in,
  input  logic                         coord_in_valid,
  output logic                         coord_in_ready,
  input  logic [NUM_CH*(DATA_WIDTH+1)-1:0] val_in,
  input  logic [NUM_CH-1:0]            val_in_valid,
  output logic [NUM_CH-1:0]            val_in_ready,
  output logic [DATA_WIDTH:0]          coord_out,
  output logic                         coord_out_valid,
  input  logic                         coord_out_ready,
  output logic [NUM_CH*(DATA_WIDTH+1)-1:0] val_out,
  output logic [NUM_CH-1:0]            val_out_valid,
  input  logic [NUM_CH-1:0]            val_out_ready,
  output logic                         protocol_err
`ifdef CRDDROP_MULTI_STATS_EN
  , output logic [31:0]                drop_count
  , output logic [31:0]                pass_count
`endif
);

  localparam int W  = DATA_WIDTH;
  localparam int TW = W + 1;
  localparam int NL = NUM_CH + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [TW-1:0] tok [NL];
  logic [TW-1:0] mem [NL][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr [NL];
  logic [AW-1:0] wr_ptr [NL];
  logic [CW-1:0] cnt [NL];
  logic [NL-1:0] full, empty, pop, out_ready, nxt_empty;

  logic can_accept, all_valid, fire;
  logic all_data, all_ctrl, ctrl_same, any_zero, all_zero;
  logic is_done, is_stop, ctrl_ok, drop, push, mismatch;

  // lane 0 is the coordinate lane, lane i+1 carries value channel i
  always_comb begin
    tok[0] = coord_in;
    for (int i = 0; i < NUM_CH; i++) tok[i+1] = val_in[i*TW +: TW];
  end

  always_comb begin
    out_ready = {val_out_ready, coord_out_ready};
    for (int l = 0; l < NL; l++) begin
      full[l]      = (cnt[l] == CW'(FIFO_DEPTH));
      empty[l]     = (cnt[l] == '0);
      pop[l]       = ~empty[l] & out_ready[l];
      nxt_empty[l] = empty[l] | ((cnt[l] == CW'(1)) & pop[l]);
    end
  end

  assign can_accept     = (state == RUN) & tile_en & ~|full & ~rst & ~flush;
  assign all_valid      = coord_in_valid & (&val_in_valid);
  assign fire           = can_accept & all_valid;
  assign coord_in_ready = fire;
  assign val_in_ready   = {NUM_CH{fire}};

  always_comb begin
    all_data  = 1'b1;
    all_ctrl  = 1'b1;
    ctrl_same = 1'b1;
    any_zero  = 1'b0;
    all_zero  = 1'b1;
    for (int l = 0; l < NL; l++) begin
      if (tok[l][W]) all_data = 1'b0;
      else           all_ctrl = 1'b0;
      if (tok[l] != tok[0]) ctrl_same = 1'b0;
    end
    for (int l = 1; l < NL; l++) begin
      if (tok[l][W-1:0] == '0) any_zero = 1'b1;
      else                     all_zero = 1'b0;
    end
  end

  assign is_done  = (tok[0][W-1:0] == W'('h100));
  assign is_stop  = (tok[0][W-1:0] <  W'('h100));
  assign ctrl_ok  = all_ctrl & ctrl_same & (is_done | is_stop);
  assign drop     = all_data & (drop_mode ? any_zero : all_zero);
  assign push     = fire & ((all_data & ~drop) | ctrl_ok);
  assign mismatch = fire & ~all_data & ~ctrl_ok;

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      for (int l = 0; l < NL; l++) begin
        rd_ptr[l] <= '0;
        wr_ptr[l] <= '0;
        cnt[l]    <= '0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (push)   wr_ptr[l] <= wr_ptr[l] + AW'(1);
        if (pop[l]) rd_ptr[l] <= rd_ptr[l] + AW'(1);
        cnt[l] <= cnt[l] + CW'(push) - CW'(pop[l]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      for (int l = 0; l < NL; l++) mem[l][wr_ptr[l]] <= tok[l];
  end

  always_comb begin
    coord_out       = mem[0][rd_ptr[0]];
    coord_out_valid = ~empty[0];
    for (int i = 0; i < NUM_CH; i++) begin
      val_out[i*TW +: TW] = mem[i+1][rd_ptr[i+1]];
      val_out_valid[i]    = ~empty[i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst | flush) state <= RUN;
    else             state <= state_nx;
  end

  // DRAIN leaves as soon as the lanes will be empty, so the next
  // acceptance lands the cycle after the final pop
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:   if (push & all_ctrl & is_done) state_nx = DRAIN;
      DRAIN: if (&nxt_empty) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst | flush) protocol_err <= 1'b0;
    else if (mismatch) protocol_err <= 1'b1;
  end

`ifdef CRDDROP_MULTI_STATS_EN
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      drop_count <= '0;
      pass_count <= '0;
    end else if (fire & all_data) begin
      if (drop) begin
        if (drop_count != '1) drop_count <= drop_count + 32'd1;
      end else if (pass_count != '1) begin
        pass_count <= pass_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crddrop_multi.sv
// tb_crddrop_multi: scoreboard bench for crddrop_multi with NUM_CH=2, W=16, depth 2.
// Optional counters are checked when CRDDROP_MULTI_STATS_EN is defined.
module tb_crddrop_multi;
  localparam int NC = 2;
  localparam int TW = 17;
  localparam logic [TW-1:0] S0 = 17'h10000;
  localparam logic [TW-1:0] DN = 17'h10100;

  logic clk = 0, rst = 1, flush = 0, tile_en = 1, drop_mode = 0;
  logic [TW-1:0] coord_in = '0;
  logic coord_in_valid = 0, coord_in_ready;
  logic [NC*TW-1:0] val_in = '0;
  logic [NC-1:0] val_in_valid = '0, val_in_ready;
  logic [TW-1:0] coord_out;
  logic coord_out_valid, coord_out_ready = 1;
  logic [NC*TW-1:0] val_out;
  logic [NC-1:0] val_out_valid, val_out_ready = 2'b11;
  logic protocol_err;
`ifdef CRDDROP_MULTI_STATS_EN
  logic [31:0] drop_count, pass_count;
`endif

  crddrop_multi #(.NUM_CH(NC), .DATA_WIDTH(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .tile_en(tile_en),
    .drop_mode(drop_mode),
    .coord_in(coord_in), .coord_in_valid(coord_in_valid),
    .coord_in_ready(coord_in_ready),
    .val_in(val_in), .val_in_valid(val_in_valid),
    .val_in_ready(val_in_ready),
    .coord_out(coord_out), .coord_out_valid(coord_out_valid),
    .coord_out_ready(coord_out_ready),
    .val_out(val_out), .val_out_valid(val_out_valid),
    .val_out_ready(val_out_ready),
    .protocol_err(protocol_err)
`ifdef CRDDROP_MULTI_STATS_EN
    , .drop_count(drop_count), .pass_count(pass_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, accepted = 0;
  logic [TW-1:0] qc[$], q0[$], q1[$];
  logic [TW-1:0] sc[8], s0[8], s1[8];

  function automatic int cls(input logic [TW-1:0] t);
    if (!t[16]) return 0;
    if (t[15:0] == 16'h100) return 2;
    if (t[15:0] < 16'h100) return 1;
    return 3;
  endfunction

  task automatic model(input logic [TW-1:0] c, a, b);
    int k0, k1, k2;
    bit z0, z1, dr;
    k0 = cls(c); k1 = cls(a); k2 = cls(b);
    if (k0 == 0 && k1 == 0 && k2 == 0) begin
      z0 = (a[15:0] == 0);
      z1 = (b[15:0] == 0);
      dr = drop_mode ? (z0 || z1) : (z0 && z1);
      if (!dr) begin qc.push_back(c); q0.push_back(a); q1.push_back(b); end
    end else if (k0 != 0 && k0 != 3 && c == a && c == b) begin
      qc.push_back(c); q0.push_back(a); q1.push_back(b);
    end
  endtask

  // output side of the scoreboard
  always @(negedge clk) begin
    if (coord_out_valid && coord_out_ready) begin
      checks++;
      if (qc.size() == 0 || coord_out !== qc[0]) begin
        errors++;
        $display("FAIL coord_lane got=%h want=%h", coord_out, qc.size() ? qc[0] : 17'hx);
      end
      if (qc.size() != 0) qc.delete(0);
    end
    if (val_out_valid[0] && val_out_ready[0]) begin
      checks++;
      if (q0.size() == 0 || val_out[TW-1:0] !== q0[0]) begin
        errors++;
        $display("FAIL val0_lane got=%h want=%h", val_out[TW-1:0], q0.size() ? q0[0] : 17'hx);
      end
      if (q0.size() != 0) q0.delete(0);
    end
    if (val_out_valid[1] && val_out_ready[1]) begin
      checks++;
      if (q1.size() == 0 || val_out[2*TW-1:TW] !== q1[0]) begin
        errors++;
        $display("FAIL val1_lane got=%h want=%h", val_out[2*TW-1:TW], q1.size() ? q1[0] : 17'hx);
      end
      if (q1.size() != 0) q1.delete(0);
    end
  end

  task automatic run_stream(input int n);
    int cyc;
    bit fired;
    for (int k = 0; k < n; k++) begin
      coord_in = sc[k]; val_in = {s1[k], s0[k]};
      coord_in_valid = 1; val_in_valid = 2'b11;
      fired = 0; cyc = 0;
      while (!fired && cyc < 60) begin
        @(negedge clk);
        checks++;
        if (val_in_ready !== {NC{coord_in_ready}}) begin
          errors++;
          $display("FAIL ready_align got=%b want=%b", val_in_ready, {NC{coord_in_ready}});
        end
        if (coord_in_ready) begin
          fired = 1; accepted++;
          model(sc[k], s0[k], s1[k]);
        end
        @(posedge clk); #1;
        cyc++;
      end
      if (!fired) begin
        checks++; errors++;
        $display("FAIL accept_timeout got=no_fire want=fire elem=%0d", k);
      end
    end
    coord_in_valid = 0; val_in_valid = '0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int c = 0; c < 100 && !idle; c++) begin
      @(negedge clk);
      idle = (qc.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
              !coord_out_valid && val_out_valid == 0);
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL drain_idle got=busy want=idle pend=%0d", qc.size() + q0.size() + q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; coord_in = 17'h5; val_in = {17'h5, 17'h5};
    coord_in_valid = 1; val_in_valid = 2'b11;
    @(negedge clk);
    checks++;
    if ({coord_in_ready, val_in_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got=%b want=000", {coord_in_ready, val_in_ready});
    end
    checks++;
    if ({coord_out_valid, val_out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_valid got=%b want=000", {coord_out_valid, val_out_valid});
    end
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b want=0", protocol_err);
    end
    @(posedge clk); #1;
    coord_in_valid = 0; val_in_valid = '0; rst = 0;
    @(negedge clk);
    checks++;
    if ({coord_in_ready, protocol_err} !== 2'b00) begin
      errors++; $display("FAIL idle_ready got=%b want=00", {coord_in_ready, protocol_err});
    end
    @(posedge clk); #1;
  endtask

  task automatic load_plan();
    sc[0] = 17'd0; s0[0] = 17'd5; s1[0] = 17'd0;
    sc[1] = 17'd1; s0[1] = 17'd0; s1[1] = 17'd0;
    sc[2] = 17'd2; s0[2] = 17'd7; s1[2] = 17'd3;
    sc[3] = S0;    s0[3] = S0;    s1[3] = S0;
    sc[4] = DN;    s0[4] = DN;    s1[4] = DN;
  endtask

  task automatic test_mode0();
    drop_mode = 0; load_plan();
    run_stream(5);
    wait_idle();
`ifdef CRDDROP_MULTI_STATS_EN
    checks++;
    if (drop_count !== 32'd1 || pass_count !== 32'd2) begin
      errors++; $display("FAIL stats_mode0 got=%0d/%0d want=1/2", drop_count, pass_count);
    end
`endif
  endtask

  task automatic test_mode1();
    drop_mode = 1; load_plan();
    run_stream(5);
    wait_idle();
    drop_mode = 0;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) begin
      sc[k] = 17'(10 + k); s0[k] = 17'(k + 1); s1[k] = 17'(k + 1);
    end
    sc[4] = DN; s0[4] = DN; s1[4] = DN;
    coord_out_ready = 0; accepted = 0;
    fork
      run_stream(5);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (accepted != 2 || coord_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_accept got=%0d/%b want=2/0", accepted, coord_in_ready);
        end
        @(posedge clk); #1;
        coord_out_ready = 1;
      end
    join
    wait_idle();
  endtask

  task automatic test_drain();
    int last_pop, fire_cyc;
    logic [2:0] fv;
    sc[0] = 17'd3; s0[0] = 17'd1; s1[0] = 17'd1;
    sc[1] = DN;    s0[1] = DN;    s1[1] = DN;
    val_out_ready = 2'b01;
    run_stream(2);
    coord_in = 17'd9; val_in = {17'd2, 17'd2};
    coord_in_valid = 1; val_in_valid = 2'b11;
    last_pop = -1; fire_cyc = -1; fv = 3'bxxx;
    for (int c = 0; c < 40 && fire_cyc < 0; c++) begin
      @(negedge clk);
      if (coord_in_ready) begin
        fire_cyc = c;
        fv = {val_out_valid, coord_out_valid};
        model(17'd9, 17'd2, 17'd2);
      end else if (|({val_out_valid, coord_out_valid} & {val_out_ready, coord_out_ready})) begin
        last_pop = c;
      end
      @(posedge clk); #1;
      if (c == 4) val_out_ready = 2'b11;
    end
    coord_in_valid = 0; val_in_valid = '0;
    checks++;
    if (last_pop < 5 || fire_cyc != last_pop + 1) begin
      errors++; $display("FAIL drain_exit got=%0d want=%0d", fire_cyc, last_pop + 1);
    end
    checks++;
    if (fv !== 3'b000) begin
      errors++; $display("FAIL drain_empty got=%b want=000", fv);
    end
    wait_idle();
  endtask

  task automatic test_mismatch();
    sc[0] = S0; s0[0] = 17'd4; s1[0] = S0;
    run_stream(1);
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++; $display("FAIL mismatch_err got=%b want=1", protocol_err);
    end
    checks++;
    if ({coord_out_valid, val_out_valid} !== 3'b000) begin
      errors++; $display("FAIL mismatch_push got=%b want=000", {coord_out_valid, val_out_valid});
    end
    @(posedge clk); #1;
    sc[0] = 17'd7; s0[0] = 17'd7; s1[0] = 17'd7;
    run_stream(1);
    wait_idle();
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got=%b want=1", protocol_err);
    end
  endtask

  task automatic test_clear_mid(input bit use_rst);
    coord_out_ready = 0; val_out_ready = 2'b00;
    sc[0] = 17'd20; s0[0] = 17'd1; s1[0] = 17'd1;
    sc[1] = 17'd21; s0[1] = 17'd2; s1[1] = 17'd2;
    run_stream(2);
    @(negedge clk);
    checks++;
    if ({coord_out_valid, val_out_valid} !== 3'b111) begin
      errors++; $display("FAIL buffered got=%b want=111", {coord_out_valid, val_out_valid});
    end
    @(posedge clk); #1;
    if (use_rst) rst = 1; else flush = 1;
    qc.delete(); q0.delete(); q1.delete();
    @(posedge clk); #1;
    rst = 0; flush = 0;
    @(negedge clk);
    checks++;
    if ({coord_out_valid, val_out_valid, protocol_err} !== 4'b0000) begin
      errors++;
      $display("FAIL clear_mid got=%b want=0000 rst=%0d", {coord_out_valid, val_out_valid, protocol_err}, use_rst);
    end
`ifdef CRDDROP_MULTI_STATS_EN
    checks++;
    if (drop_count !== 32'd0 || pass_count !== 32'd0) begin
      errors++; $display("FAIL stats_clear got=%0d/%0d want=0/0", drop_count, pass_count);
    end
`endif
    @(posedge clk); #1;
    coord_out_ready = 1; val_out_ready = 2'b11;
    sc[0] = 17'd30; s0[0] = 17'd5; s1[0] = 17'd5;
    run_stream(1);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      sc[k] = 17'(40 + k); s0[k] = 17'(k[0] ? 0 : k + 1); s1[k] = 17'(k);
    end
    sc[6] = 17'h10001; s0[6] = 17'h10001; s1[6] = 17'h10001;
    sc[7] = DN; s0[7] = DN; s1[7] = DN;
    run_stream(8);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_backpressure();
    test_drain();
    test_mismatch();
    test_clear_mid(1'b0);
    test_mismatch();
    test_clear_mid(1'b1);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
